// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank: address map,
// unlock key values and the CTRL lock state encoding.
package spi_reg_pkg;

  // Register address map
  localparam int unsigned AddrId      = 0;
  localparam int unsigned AddrCtrl    = 1;
  localparam int unsigned AddrStatus  = 2;
  localparam int unsigned AddrKey     = 3;
  localparam int unsigned AddrErrCnt  = 4;
  localparam int unsigned AddrRamBase = 8;

  // Unlock sequence; zero-extended to the register width at the point of use
  localparam logic [15:0] Key1 = 16'hA5A5;
  localparam logic [15:0] Key2 = 16'h5A5A;

  typedef enum logic [1:0] {
    StLocked,
    StKeyHalf,
    StUnlocked
  } lock_state_e;

endpackage

// File: rtl/spi_w1c_reg.sv
// Sticky status register: bits set by hardware level inputs, cleared by
// writing 1. A set and a clear on the same bit in one cycle leave it set.
module spi_w1c_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             spi_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set_bits,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_bits,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next state: apply clear mask first, then OR in set so set wins
  always_comb begin
    value_d = value_q;
    if (clr_en) begin
      value_d = value_d & ~clr_bits;
    end
    value_d = value_d | set_bits;
  end

  // Status storage
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-accessible register bank: ID, lockable CTRL, sticky W1C STATUS, KEY,
// ERR_CNT and a scratch RAM filling the rest of the address space.
// Build option: define SPI_REG_LOCK_EN to enable the CTRL write lock
// (key sequence FSM and rejected-write counter). Without it CTRL is always
// writable, locked is 0, ERR_CNT reads 0 and KEY writes have no effect.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned       DWIDTH   = 16,
  parameter int unsigned       ALINES   = 7,
  parameter logic [DWIDTH-1:0] ID_VALUE = DWIDTH'(16'h5A01)
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ALINES-1:0] addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data,
  input  logic [DWIDTH-1:0] status_in,
  output logic [DWIDTH-1:0] ctrl_out,
  output logic              locked
);

  localparam int unsigned RamWords = 2 ** ALINES;

  logic              sel_ctrl;
  logic              sel_status;
  logic              sel_key;
  logic              sel_ram;
  logic              ctrl_wr_ok;
  logic [DWIDTH-1:0] ctrl_q;
  logic [DWIDTH-1:0] status_q;
  logic [DWIDTH-1:0] err_cnt;
  logic [DWIDTH-1:0] rd_value;
  logic [DWIDTH-1:0] rd_data_q;

  // Storage words below AddrRamBase exist but are never written or read
  logic [DWIDTH-1:0] ram [RamWords];

  assign sel_ctrl   = (addr == ALINES'(AddrCtrl));
  assign sel_status = (addr == ALINES'(AddrStatus));
  assign sel_key    = (addr == ALINES'(AddrKey));
  assign sel_ram    = (addr >= ALINES'(AddrRamBase));

`ifdef SPI_REG_LOCK_EN
  localparam logic [DWIDTH-1:0] Key1Ext = DWIDTH'(Key1);
  localparam logic [DWIDTH-1:0] Key2Ext = DWIDTH'(Key2);

  lock_state_e       state_q;
  logic              locked_q;
  logic [DWIDTH-1:0] err_cnt_q;

  // Lock FSM; any write while half-keyed that is not KEY2 to KEY re-locks
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q  <= StLocked;
      locked_q <= 1'b1;
    end else if (wr) begin
      unique case (state_q)
        StLocked: begin
          if (sel_key && wr_data == Key1Ext) begin
            state_q <= StKeyHalf;
          end
          locked_q <= 1'b1;
        end
        StKeyHalf: begin
          if (sel_key && wr_data == Key2Ext) begin
            state_q  <= StUnlocked;
            locked_q <= 1'b0;
          end else begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
        end
        StUnlocked: begin
          if (sel_key) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StLocked;
          locked_q <= 1'b1;
        end
      endcase
    end
  end

  // Count rejected CTRL writes, saturating at all-ones
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (wr && sel_ctrl && state_q != StUnlocked && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + DWIDTH'(1);
    end
  end

  assign ctrl_wr_ok = (state_q == StUnlocked);
  assign locked     = locked_q;
  assign err_cnt    = err_cnt_q;
`else
  assign ctrl_wr_ok = 1'b1;
  assign locked     = 1'b0;
  assign err_cnt    = '0;
`endif

  // CTRL register, output directly with no extra stage
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (wr && sel_ctrl && ctrl_wr_ok) begin
      ctrl_q <= wr_data;
    end
  end

  assign ctrl_out = ctrl_q;

  // Sticky event bits
  spi_w1c_reg #(
    .WIDTH(DWIDTH)
  ) u_status (
    .spi_clk  (spi_clk),
    .reset    (reset),
    .set_bits (status_in),
    .clr_en   (wr && sel_status),
    .clr_bits (wr_data),
    .value    (status_q)
  );

  // Scratch RAM write port; contents intentionally not reset
  always_ff @(posedge spi_clk) begin
    if (wr && sel_ram) begin
      ram[addr] <= wr_data;
    end
  end

  // Read decode; KEY and reserved addresses read as zero
  always_comb begin
    rd_value = '0;
    if (sel_ram) begin
      rd_value = ram[addr];
    end else begin
      case (addr)
        ALINES'(AddrId):     rd_value = ID_VALUE;
        ALINES'(AddrCtrl):   rd_value = ctrl_q;
        ALINES'(AddrStatus): rd_value = status_q;
        ALINES'(AddrErrCnt): rd_value = err_cnt;
        default:             rd_value = '0;
      endcase
    end
  end

  // Registered read data; captures pre-write state when rd and wr coincide
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd) begin
      rd_data_q <= rd_value;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank. Expectations follow the build:
// SPI_REG_LOCK_EN defined selects the locked-CTRL expectations.
module tb_spi_reg_bank;

`ifdef SPI_REG_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic        spi_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        wr      = 1'b0;
  logic        rd      = 1'b0;
  logic [6:0]  addr    = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic [15:0] status_in = '0;
  logic [15:0] ctrl_out;
  logic        locked;

  spi_reg_bank dut (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .status_in (status_in),
    .ctrl_out  (ctrl_out),
    .locked    (locked)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] status;
    logic [15:0] exp_rd;
    logic [15:0] exp_ctrl;
    logic        exp_locked;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] last_rd;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] pick(input logic [15:0] lk, input logic [15:0] nl);
    return LockEn ? lk : nl;
  endfunction

  function automatic logic lk(input logic v);
    return LockEn ? v : 1'b0;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [6:0] a, input logic [15:0] d,
                     input logic [15:0] st, input logic [15:0] erd, input logic [15:0] ectl,
                     input logic elk);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.status = st;
    v.exp_rd = erd; v.exp_ctrl = ectl; v.exp_locked = elk;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive, push expected read, clock, then compare
  task automatic step(input string name, input logic w, input logic r, input logic [6:0] a,
                      input logic [15:0] d, input logic [15:0] st, input logic [15:0] erd,
                      input logic [15:0] ectl, input logic elk);
    logic [15:0] exp;
    wr = w; rd = r; addr = a; wr_data = d; status_in = st;
    if (r) sb.push_back(erd);
    @(posedge spi_clk);
    #1;
    wr = 1'b0; rd = 1'b0; status_in = '0;
    if (r) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        exp = sb.pop_front();
        check({name, " rd_data"}, rd_data, exp);
        last_rd = exp;
      end
    end else begin
      check({name, " rd_data hold"}, rd_data, last_rd);
    end
    check({name, " ctrl_out"}, ctrl_out, ectl);
    check({name, " locked"}, {15'd0, locked}, {15'd0, elk});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr = 1'b0; rd = 1'b0; status_in = '0;
    repeat (2) @(posedge spi_clk);
    #1;
    reset = 1'b0;
    last_rd = '0;
  endtask

  initial begin
    logic [15:0] c1;
    last_rd = '0;
    do_reset();
    check("reset rd_data", rd_data, 16'h0000);
    check("reset ctrl_out", ctrl_out, 16'h0000);
    check("reset locked", {15'd0, locked}, {15'd0, lk(1'b1)});

    // wr rd addr data status exp_rd exp_ctrl exp_locked
    add(0, 1, 7'h00, 16'h0000, 16'h0, 16'h5A01, 16'h0, lk(1));
    add(0, 1, 7'h01, 16'h0000, 16'h0, 16'h0000, 16'h0, lk(1));
    add(1, 0, 7'h01, 16'h1234, 16'h0, 16'h0, pick(16'h0, 16'h1234), lk(1));
    add(0, 1, 7'h01, 16'h0000, 16'h0, pick(16'h0, 16'h1234), pick(16'h0, 16'h1234), lk(1));
    add(0, 1, 7'h04, 16'h0000, 16'h0, pick(16'd1, 16'd0), pick(16'h0, 16'h1234), lk(1));
    add(1, 0, 7'h03, 16'hA5A5, 16'h0, 16'h0, pick(16'h0, 16'h1234), lk(1));
    add(1, 0, 7'h03, 16'h5A5A, 16'h0, 16'h0, pick(16'h0, 16'h1234), lk(0));
    add(1, 0, 7'h01, 16'h00FF, 16'h0, 16'h0, 16'h00FF, lk(0));
    add(0, 1, 7'h01, 16'h0000, 16'h0, 16'h00FF, 16'h00FF, lk(0));
    add(0, 1, 7'h03, 16'h0000, 16'h0, 16'h0000, 16'h00FF, lk(0));
    add(1, 0, 7'h03, 16'hA5A5, 16'h0, 16'h0, 16'h00FF, lk(1));
    add(1, 0, 7'h01, 16'h0F0F, 16'h0, 16'h0, pick(16'h00FF, 16'h0F0F), lk(1));
    add(0, 1, 7'h04, 16'h0000, 16'h0, pick(16'd2, 16'd0), pick(16'h00FF, 16'h0F0F), lk(1));
    // Interrupted key sequence
    c1 = pick(16'h00FF, 16'hAAAA);
    add(1, 0, 7'h03, 16'hA5A5, 16'h0, 16'h0, pick(16'h00FF, 16'h0F0F), lk(1));
    add(1, 0, 7'h08, 16'h0001, 16'h0, 16'h0, pick(16'h00FF, 16'h0F0F), lk(1));
    add(1, 0, 7'h03, 16'h5A5A, 16'h0, 16'h0, pick(16'h00FF, 16'h0F0F), lk(1));
    add(1, 0, 7'h01, 16'hAAAA, 16'h0, 16'h0, c1, lk(1));
    add(0, 1, 7'h08, 16'h0000, 16'h0, 16'h0001, c1, lk(1));
    add(0, 1, 7'h04, 16'h0000, 16'h0, pick(16'd3, 16'd0), c1, lk(1));
    // Read-only and reserved addresses
    add(1, 0, 7'h00, 16'hFFFF, 16'h0, 16'h0, c1, lk(1));
    add(0, 1, 7'h00, 16'h0000, 16'h0, 16'h5A01, c1, lk(1));
    add(1, 0, 7'h04, 16'h1234, 16'h0, 16'h0, c1, lk(1));
    add(0, 1, 7'h04, 16'h0000, 16'h0, pick(16'd3, 16'd0), c1, lk(1));
    add(1, 0, 7'h05, 16'h1234, 16'h0, 16'h0, c1, lk(1));
    add(0, 1, 7'h05, 16'h0000, 16'h0, 16'h0000, c1, lk(1));
    add(0, 1, 7'h07, 16'h0000, 16'h0, 16'h0000, c1, lk(1));
    // Scratch RAM and read/write collision
    add(1, 0, 7'h7F, 16'h1111, 16'h0, 16'h0, c1, lk(1));
    add(1, 1, 7'h7F, 16'hBEEF, 16'h0, 16'h1111, c1, lk(1));
    add(0, 1, 7'h7F, 16'h0000, 16'h0, 16'hBEEF, c1, lk(1));
    add(0, 1, 7'h08, 16'h0000, 16'h0, 16'h0001, c1, lk(1));
    // Sticky status
    add(0, 0, 7'h00, 16'h0000, 16'h0008, 16'h0, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0000, 16'h0008, c1, lk(1));
    add(1, 1, 7'h02, 16'h0008, 16'h0008, 16'h0008, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0000, 16'h0008, c1, lk(1));
    add(1, 0, 7'h02, 16'h0008, 16'h0000, 16'h0, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0000, 16'h0000, c1, lk(1));
    add(0, 0, 7'h00, 16'h0000, 16'h0005, 16'h0, c1, lk(1));
    add(1, 0, 7'h02, 16'h0001, 16'h0000, 16'h0, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0000, 16'h0004, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0010, 16'h0004, c1, lk(1));
    add(0, 1, 7'h02, 16'h0000, 16'h0000, 16'h0014, c1, lk(1));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
           vecs[i].status, vecs[i].exp_rd, vecs[i].exp_ctrl, vecs[i].exp_locked);
    end

    // Reset in the middle of a key sequence aborts it
    step("key1 pre-reset", 1, 0, 7'h03, 16'hA5A5, 16'h0, 16'h0, c1, lk(1));
    do_reset();
    check("mid reset rd_data", rd_data, 16'h0000);
    check("mid reset ctrl_out", ctrl_out, 16'h0000);
    check("mid reset locked", {15'd0, locked}, {15'd0, lk(1'b1)});
    step("key2 post-reset", 1, 0, 7'h03, 16'h5A5A, 16'h0, 16'h0, 16'h0, lk(1));
    step("ctrl post-reset", 1, 0, 7'h01, 16'h00FF, 16'h0, 16'h0, pick(16'h0, 16'h00FF), lk(1));
    step("errcnt post-reset", 0, 1, 7'h04, 16'h0, 16'h0, pick(16'd1, 16'd0),
         pick(16'h0, 16'h00FF), lk(1));
    step("status post-reset", 0, 1, 7'h02, 16'h0, 16'h0, 16'h0000,
         pick(16'h0, 16'h00FF), lk(1));

    // Counter saturation: already at 1, push well past 0xFFFF rejects
    if (LockEn) begin
      wr = 1'b1; addr = 7'h01; wr_data = 16'h1234;
      repeat (65540) @(posedge spi_clk);
      #1;
      wr = 1'b0;
      step("errcnt saturated", 0, 1, 7'h04, 16'h0, 16'h0, 16'hFFFF, 16'h0, 1'b1);
      step("ctrl after rejects", 0, 1, 7'h01, 16'h0, 16'h0, 16'h0000, 16'h0, 1'b1);
    end

    check("scoreboard drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, register data width (>=16).
REQ-002 SHALL have parameter ALINES, default 7, register address width.
REQ-003 SHALL have parameter ID_VALUE, default 16'h5A01, DWIDTH-wide value returned by the ID register.
REQ-004 SHALL have port spi_clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr  input  1  single-cycle write strobe from the SPI slave.
REQ-007 SHALL have port rd  input  1  single-cycle read strobe from the SPI slave.
REQ-008 SHALL have port addr  input  ALINES  register address.
REQ-009 SHALL have port wr_data  input  DWIDTH  write data, valid when wr=1.
REQ-010 SHALL have port rd_data  output  DWIDTH  registered read data.
REQ-011 SHALL have port status_in  input  DWIDTH  hardware event bits, level, sampled every cycle.
REQ-012 SHALL have port ctrl_out  output  DWIDTH  current CTRL register contents.
REQ-013 SHALL have port locked  output  1  high while CTRL writes are blocked.

Function
REQ-014 SHALL decode this map: 0x00 ID (RO); 0x01 CTRL (RW, lockable); 0x02 STATUS (W1C, sticky); 0x03 KEY (WO, reads 0); 0x04 ERR_CNT (RO); 0x05-0x07 reserved (read 0, writes ignored); 0x08 to 2**ALINES-1 scratch RAM (RW).
REQ-015 SHALL update rd_data one cycle after rd=1 with the addressed value; rd_data holds between reads.
REQ-016 SHALL, with rd and wr in the same cycle, return the pre-write value and also perform the write.
REQ-017 SHALL set STATUS bit n whenever status_in[n]=1; write of 1 to bit n clears it; set wins over simultaneous clear.
REQ-018 SHALL drive ctrl_out from the CTRL register with zero added latency.
REQ-019 SHALL increment ERR_CNT by 1 on each rejected CTRL write, saturating at all-ones.
REQ-020 SHALL ignore writes to ID, ERR_CNT and reserved addresses without counting an error.
REQ-021 SHALL implement lock FSM states LOCKED, KEY_HALF, UNLOCKED.
REQ-022 SHALL transition LOCKED->KEY_HALF on KEY write of KEY1; KEY_HALF->UNLOCKED on KEY write of KEY2; KEY_HALF->LOCKED on any other write at any address; UNLOCKED->LOCKED on any KEY write.
REQ-023 SHALL accept CTRL writes only in UNLOCKED; locked=1 in LOCKED and KEY_HALF.
REQ-024 SHALL treat wr with addr outside decoded map as impossible; addr wraps at 2**ALINES (full decode, no aliasing).

Reset
REQ-025 SHALL on reset clear rd_data, CTRL, STATUS, ERR_CNT to 0, lock FSM to LOCKED, locked=1.
REQ-026 SHALL leave scratch RAM contents undefined after reset (no reset on storage).
REQ-027 SHALL abort any partial key sequence on reset mid-sequence.

Configuration
REQ-028 SHALL, with SPI_REG_LOCK_EN defined, implement REQ-021..REQ-023 and ERR_CNT counting.
REQ-029 SHALL, without SPI_REG_LOCK_EN, accept all CTRL writes, tie locked to 0, hold ERR_CNT at 0, and ignore KEY writes.

Structure
REQ-030 SHALL take register address constants, KEY1=16'hA5A5, KEY2=16'h5A5A (zero-extended to DWIDTH) and the lock-state enum from package spi_reg_pkg.
REQ-031 SHALL place the W1C sticky status logic in sub-module spi_w1c_reg; no other sub-modules.

Verification
REQ-032 SHALL test: reset, rd 0x00 -> rd_data=ID_VALUE next cycle; rd 0x01 -> 0x0000, locked=1.
REQ-033 SHALL test: locked, wr 0x01=0x1234 -> ctrl_out=0, ERR_CNT reads 1; KEY1 then KEY2 to 0x03, wr 0x01=0x1234 -> ctrl_out=0x1234, locked=0.
REQ-034 SHALL test: KEY1, then wr 0x08=0x0001, then KEY2 -> remains LOCKED; CTRL write rejected.
REQ-035 SHALL test: status_in[3] pulse -> STATUS reads 0x0008; wr 0x02=0x0008 with status_in[3]=1 same cycle -> still 0x0008; later clear -> 0x0000.
REQ-036 SHALL test: wr 0x7F=0xBEEF and rd 0x7F same cycle -> rd_data old value, next rd -> 0xBEEF; ERR_CNT saturates at 0xFFFF after 65536+ rejects.
REQ-037 SHALL test: build without SPI_REG_LOCK_EN -> wr 0x01=0x00FF after reset -> ctrl_out=0x00FF, locked=0.
